// File: rtl/trim_pkg.sv
// rtl/trim_pkg.sv - shared state encoding and default code width for the trim SAR controller
package trim_pkg;

    localparam int TRIM_CODE_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_SETTLE,
        S_SAMPLE,
        S_FINAL
    } trim_state_t;

endpackage

// File: rtl/trim_tick_gen.sv
// rtl/trim_tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV clocks while enabled
//   CLOCK_50 in  system clock
//   RST      in  asynchronous active-high reset
//   enable   in  count while high; counter held at zero while low
//   tick     out one-cycle pulse when the counter reaches TICK_DIV-1
module trim_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic CLOCK_50,
    input  logic RST,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (!enable || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/trim_sar_ctrl.sv
// rtl/trim_sar_ctrl.sv - successive-approximation trim search driving a serial trim shift register
//   CLOCK_50    in  system clock
//   RST         in  asynchronous active-high reset
//   START       in  async level; synced rising edge starts a search when idle
//   CMP_IN      in  async comparator; 1 = trimmed output above target
//   ENCLK       out registered serial trim clock
//   DOUT        out serial trim data, LSB first
//   BUSY        out search in progress
//   DONE        out sticky completion flag, cleared by the next accepted START
//   TRIM_RESULT out final code, valid while DONE
//   TRIAL_CODE  out code currently shifted/evaluated
module trim_sar_ctrl
    import trim_pkg::*;
#(
    parameter int CODE_W       = TRIM_CODE_W,
    parameter int TICK_DIV     = 12500000,
    parameter int SETTLE_TICKS = 3
) (
    input  logic              CLOCK_50,
    input  logic              RST,
    input  logic              START,
    input  logic              CMP_IN,
    output logic              ENCLK,
    output logic              DOUT,
    output logic              BUSY,
    output logic              DONE,
    output logic [CODE_W-1:0] TRIM_RESULT,
    output logic [CODE_W-1:0] TRIAL_CODE
);

    localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int NW = $clog2(CODE_W + 1);
    localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
    localparam logic [NW-1:0] N_LAST      = NW'(CODE_W);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS - 1);
    localparam logic [BW-1:0] BIT_TOP     = BW'(CODE_W - 1);

    trim_state_t state, state_next;

    logic              start_s1, start_s2, start_s3;
    logic              cmp_s1, cmp_s2;
    logic              start_rise;
    logic              tick;
    logic [BW-1:0]     bit_idx;
    logic [CODE_W-1:0] acc;
    logic [CODE_W-1:0] shreg;
    logic [NW-1:0]     n;
    logic              phase;
    logic [SW-1:0]     settle_cnt;
    logic [CODE_W-1:0] trial;
    logic [CODE_W-1:0] acc_sampled;
    logic              shift_end;

    trim_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .enable   (state != S_IDLE),
        .tick     (tick)
    );

    // Third START flop exists only to form the edge; the level itself is never used.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_s3 <= 1'b0;
            cmp_s1   <= 1'b0;
            cmp_s2   <= 1'b0;
        end else begin
            start_s1 <= START;
            start_s2 <= start_s1;
            start_s3 <= start_s2;
            cmp_s1   <= CMP_IN;
            cmp_s2   <= cmp_s1;
        end
    end

    assign start_rise = start_s2 && !start_s3;
    assign trial      = acc | (CODE_W'(1) << bit_idx);
    // A frame ends on the first phase-A tick after the last rising ENCLK.
    assign shift_end  = tick && !phase && (n == N_LAST);

    always_comb begin
        acc_sampled          = acc;
        acc_sampled[bit_idx] = ~cmp_s2;
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start_rise) state_next = S_LOAD;
            S_LOAD:   state_next = S_SHIFT;
            S_SHIFT:  if (shift_end) state_next = S_SETTLE;
            S_SETTLE: if (tick && settle_cnt == SETTLE_LAST) state_next = S_SAMPLE;
            S_SAMPLE: state_next = (bit_idx == '0) ? S_FINAL : S_LOAD;
            S_FINAL:  if (shift_end) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            ENCLK       <= 1'b0;
            DOUT        <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            TRIM_RESULT <= '0;
            TRIAL_CODE  <= '0;
            bit_idx     <= '0;
            acc         <= '0;
            shreg       <= '0;
            n           <= '0;
            phase       <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        bit_idx <= BIT_TOP;
                        acc     <= '0;
                        DONE    <= 1'b0;
                        BUSY    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    TRIAL_CODE <= trial;
                    shreg      <= trial;
                    n          <= '0;
                    phase      <= 1'b0;
                end
                S_SHIFT, S_FINAL: begin
                    if (tick) begin
                        if (!phase) begin
                            ENCLK <= 1'b0;
                            if (n == N_LAST) begin
                                DOUT       <= 1'b0;
                                settle_cnt <= '0;
                                if (state == S_FINAL) begin
                                    TRIM_RESULT <= acc;
                                    DONE        <= 1'b1;
                                    BUSY        <= 1'b0;
                                end
                            end else begin
                                DOUT  <= shreg[0];
                                phase <= 1'b1;
                            end
                        end else begin
                            ENCLK <= 1'b1;
                            shreg <= shreg >> 1;
                            n     <= n + NW'(1);
                            phase <= 1'b0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (tick) settle_cnt <= settle_cnt + SW'(1);
                end
                S_SAMPLE: begin
                    acc <= acc_sampled;
                    if (bit_idx == '0) begin
                        TRIAL_CODE <= acc_sampled;
                        shreg      <= acc_sampled;
                        n          <= '0;
                        phase      <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx - BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
